nios2_oci_dct_trace_capture: RTL and testbench

Parametrised successor to the OCI test-bench stub: an active debug-trace capture block for the Nios II OCI. It samples the packed DCT trace word when the packer fills, flushes partial words on test end, and buffers the entries in a FIFO. A valid/ready port drains the FIFO toward a JTAG/debug reader or simulation monitor, and the block flags completion once the test has ended and the FIFO is empty.

---
 rtl/nios2_oci_trace_pkg.sv | 22 ++
 rtl/nios2_oci_trace_fifo.sv | 97 +++++++++
 rtl/nios2_oci_dct_trace_capture.sv | 133 +++++++++++++
 tb/tb_nios2_oci_dct_trace_capture.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and helpers for the Nios II OCI DCT trace capture block.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int DEF_COUNT_WIDTH   = 4;
  localparam int DEF_DCT_WIDTH     = 30;
  localparam int TRACE_ENTRY_WIDTH = DEF_COUNT_WIDTH + DEF_DCT_WIDTH;

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/nios2_oci_trace_fifo.sv
// Synchronous first-word-fall-through FIFO: a head register in front of a
// block-RAM style array with registered read.
module nios2_oci_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  logic pop_ok, push_ok, mem_empty;
  logic mem_we, head_from_mem, head_from_in;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LW'(DEPTH));
  assign level     = level_q;
  assign head_data = head_q;

  // Entries behind the head live in the array; at most one means the array is empty.
  assign mem_empty = (level_q <= LW'(1));
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    mem_we        = 1'b0;
    head_from_mem = 1'b0;
    head_from_in  = 1'b0;

    if (push_ok) begin
      if (empty || (pop_ok && mem_empty)) begin
        head_from_in = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (pop_ok && !mem_empty) begin
      head_from_mem = 1'b1;
      rd_ptr_d      = rd_ptr_q + 1'b1;
    end

    if (push_ok && !pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head is refilled by a synchronous array read, or directly from the input
  // when nothing is queued behind it.
  always_ff @(posedge clk) begin
    if (head_from_mem) begin
      head_q <= mem_q[rd_ptr_q];
    end else if (head_from_in) begin
      head_q <= push_data;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_trace_capture.sv
// Captures packed DCT trace words on packer fill or test-end flush, queues
// them in a FIFO for a valid/ready reader and flags completion after drain.
module nios2_oci_dct_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int DCT_WIDTH   = 30,
  parameter int COUNT_WIDTH = 4,
  parameter int FULL_COUNT  = 15,
  parameter int DEPTH       = 16,
  parameter int STAT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DCT_WIDTH-1:0]         dct_buffer,
  input  logic [COUNT_WIDTH-1:0]       dct_count,
  input  logic                         test_ending,
  input  logic                         test_has_ended,
  output logic [COUNT_WIDTH+DCT_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         overflow,
  output logic [STAT_WIDTH-1:0]        captured_count,
  output logic [STAT_WIDTH-1:0]        dropped_count,
  output logic                         done
);

  localparam int EW = COUNT_WIDTH + DCT_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] FULL_VAL = COUNT_WIDTH'(FULL_COUNT);

  trace_state_e            state_q, state_d;
  logic [COUNT_WIDTH-1:0]  prev_count_q, prev_count_d;
  logic                    overflow_q, overflow_d;
  logic [STAT_WIDTH-1:0]   captured_q, captured_d;
  logic [STAT_WIDTH-1:0]   dropped_q, dropped_d;
  logic                    done_q, done_d;

  logic          full_edge, capture, pop, drop, accept;
  logic          fifo_empty, fifo_full;
  logic [EW-1:0] entry;

  assign entry     = {dct_count, dct_buffer};
  assign full_edge = (dct_count == FULL_VAL) && (prev_count_q != FULL_VAL);
  assign rd_valid  = !fifo_empty;
  assign pop       = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign drop      = capture && fifo_full && !pop;
  assign accept    = capture && !drop;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        capture = full_edge;
        if (test_has_ended) begin
          state_d = ST_DRAIN;
        end else if (test_ending) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // A fill edge in this cycle is the same word, so one write covers both.
        capture = (dct_count != '0);
        state_d = test_has_ended ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    prev_count_d = dct_count;
    overflow_d   = overflow_q | drop;
    captured_d   = captured_q;
    dropped_d    = dropped_q;
    if (accept) begin
      captured_d = STAT_WIDTH'(sat_inc(32'(captured_q), STAT_WIDTH));
    end
    if (drop) begin
      dropped_d = STAT_WIDTH'(sat_inc(32'(dropped_q), STAT_WIDTH));
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      prev_count_q <= '0;
      overflow_q   <= 1'b0;
      captured_q   <= '0;
      dropped_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= prev_count_d;
      overflow_q   <= overflow_d;
      captured_q   <= captured_d;
      dropped_q    <= dropped_d;
      done_q       <= done_d;
    end
  end

  nios2_oci_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (entry),
    .pop       (pop),
    .head_data (rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign overflow       = overflow_q;
  assign captured_count = captured_q;
  assign dropped_count  = dropped_q;
  assign done           = done_q;

endmodule

// File: tb/tb_nios2_oci_dct_trace_capture.sv
// Self-checking bench: directed plan scenarios plus randomized traffic,
// compared each cycle against a queue-based reference model.
module tb_nios2_oci_dct_trace_capture;

  localparam int DW  = 30;
  localparam int CW  = 4;
  localparam int FC  = 15;
  localparam int DEP = 16;
  localparam int SW  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   dct_buffer;
  logic [CW-1:0]   dct_count;
  logic            test_ending;
  logic            test_has_ended;
  logic [CW+DW-1:0] rd_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [4:0]      fifo_level;
  logic            overflow;
  logic [SW-1:0]   captured_count;
  logic [SW-1:0]   dropped_count;
  logic            done;

  nios2_oci_dct_trace_capture #(
    .DCT_WIDTH   (DW),
    .COUNT_WIDTH (CW),
    .FULL_COUNT  (FC),
    .DEPTH       (DEP),
    .STAT_WIDTH  (SW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .captured_count (captured_count),
    .dropped_count  (dropped_count),
    .done           (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0=capturing, 1=flushing, 2=draining, 3=finished.
  int               m_phase;
  logic [CW+DW-1:0] m_q[$];
  logic [CW-1:0]    m_prev;
  bit               m_ovf;
  int               m_capt;
  int               m_drop;
  bit               m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit               pop_now;
    bit               cap_now;
    logic [CW+DW-1:0] ent;
    int               sz;
    sz      = m_q.size();
    pop_now = (sz > 0) && rd_ready;
    cap_now = 1'b0;
    if (m_phase == 0)      cap_now = (dct_count == CW'(FC)) && (m_prev != CW'(FC));
    else if (m_phase == 1) cap_now = (dct_count != 0);
    ent = {dct_count, dct_buffer};
    @(posedge clk);
    #1;
    if (reset) begin
      m_q.delete();
      m_phase = 0; m_prev = '0; m_ovf = 0; m_capt = 0; m_drop = 0; m_done = 0;
    end else begin
      if (pop_now) m_q.delete(0);
      if (cap_now) begin
        if (sz < DEP || pop_now) begin
          m_q.push_back(ent);
          if (m_capt < 65535) m_capt++;
        end else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      case (m_phase)
        0: m_phase = test_has_ended ? 2 : (test_ending ? 1 : 0);
        1: m_phase = test_has_ended ? 2 : 0;
        2: if (sz == 0) m_phase = 3;
        default: ;
      endcase
      m_done = (m_phase == 3);
      m_prev = dct_count;
    end
    check("rd_valid", 64'(rd_valid), 64'(m_q.size() != 0));
    check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("captured_count", 64'(captured_count), 64'(m_capt));
    check("dropped_count", 64'(dropped_count), 64'(m_drop));
    check("done", 64'(done), 64'(m_done));
    if (m_q.size() != 0) check("rd_data", 64'(rd_data), 64'(m_q[0]));
  endtask

  task automatic pulse_reset();
    reset = 1'b1; test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic full_event(input logic [DW-1:0] b);
    dct_count = '0;
    tick();
    dct_count  = CW'(FC);
    dct_buffer = b;
    tick();
  endtask

  initial begin
    reset = 1'b1; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    m_phase = 0; m_prev = '0; m_ovf = 0; m_capt = 0; m_drop = 0; m_done = 0;
    tick();
    tick();
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_level", 64'(fifo_level), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    // Packer ramp with the count held at full for three cycles.
    for (int c = 0; c < 16; c++) begin
      dct_count  = CW'(c);
      dct_buffer = (c == 15) ? 30'h155AA55A : DW'($urandom);
      tick();
    end
    tick();
    tick();
    check("plan_full_captured", 64'(captured_count), 64'd1);
    check("plan_full_data", 64'(rd_data), 64'({4'hF, 30'h155AA55A}));
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;

    // Flush of a partial word, then a flush with nothing to write.
    dct_count = 4'd5; dct_buffer = 30'h0000_0ABC; test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    tick();
    check("plan_flush_data", 64'(rd_data), 64'({4'h5, 30'h0000_0ABC}));
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    dct_count = 4'd0; test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    tick();
    tick();
    check("plan_flush_zero_valid", 64'(rd_valid), 64'd0);
    check("plan_flush_zero_capt", 64'(captured_count), 64'd2);

    // Overflow: 17 fills into a 16-entry FIFO with the reader stalled.
    pulse_reset();
    for (int i = 0; i < 17; i++) full_event(DW'($urandom));
    check("plan_ovf_level", 64'(fifo_level), 64'd16);
    check("plan_ovf_flag", 64'(overflow), 64'd1);
    check("plan_ovf_dropped", 64'(dropped_count), 64'd1);
    check("plan_ovf_captured", 64'(captured_count), 64'd16);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    rd_ready = 1'b0;
    check("plan_ovf_drained", 64'(rd_valid), 64'd0);

    // Full FIFO with a pop on the same cycle as a capture.
    pulse_reset();
    for (int i = 0; i < 16; i++) full_event(DW'($urandom));
    dct_count = '0; tick();
    dct_count = CW'(FC); dct_buffer = DW'($urandom); rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("plan_fullpop_level", 64'(fifo_level), 64'd16);
    check("plan_fullpop_ovf", 64'(overflow), 64'd0);
    check("plan_fullpop_captured", 64'(captured_count), 64'd17);

    // Randomized traffic with occasional flush requests.
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) dct_count = CW'($urandom);
      else                           dct_count = dct_count + 4'd1;
      dct_buffer  = DW'($urandom);
      rd_ready    = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      test_ending = ($urandom_range(0, 39) == 0);
      tick();
    end
    test_ending = 1'b0;

    // End of test: three queued entries drained, then done.
    pulse_reset();
    for (int i = 0; i < 3; i++) full_event(DW'($urandom));
    dct_count = '0;
    rd_ready = 1'b1; test_has_ended = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("plan_end_done", 64'(done), 64'd1);
    for (int i = 0; i < 2; i++) full_event(DW'($urandom));
    check("plan_end_ignored", 64'(captured_count), 64'd3);
    check("plan_end_empty", 64'(rd_valid), 64'd0);

    // Reset in the middle of a drain.
    pulse_reset();
    for (int i = 0; i < 8; i++) full_event(DW'($urandom));
    test_has_ended = 1'b1;
    tick();
    tick();
    check("plan_middrain_level", 64'(fifo_level), 64'd8);
    pulse_reset();
    check("plan_rst_valid", 64'(rd_valid), 64'd0);
    check("plan_rst_level", 64'(fifo_level), 64'd0);
    check("plan_rst_captured", 64'(captured_count), 64'd0);
    check("plan_rst_done", 64'(done), 64'd0);
    full_event(30'h0123_4567);
    check("plan_rst_running", 64'(captured_count), 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
